// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin between core and debug ports, one access in flight.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              core_stall,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [15:0]       c_cnt,
  output logic [15:0]       d_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              issue;
  logic              capture;
  logic              win_d;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              sel_q;
  logic              we_q;
  logic              last_q;
  logic              c_inc;
  logic              d_inc;
  logic [CNT_W-1:0]  c_cnt_q;
  logic [CNT_W-1:0]  d_cnt_q;

  // Round-robin winner selection and the winner's request fields
  always_comb begin
    win_d     = 1'b0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (c_req && d_req) begin
      win_d = ~last_q;
    end else begin
      win_d = d_req;
    end
    if (win_d) begin
      win_we    = d_we;
      win_addr  = d_addr;
      win_wdata = d_wdata;
    end else begin
      win_we    = c_we;
      win_addr  = c_addr;
      win_wdata = c_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; issue marks IDLE->ISSUE, capture marks the RDWAIT cycle
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (c_req || d_req) begin
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = we_q ? IDLE : RDWAIT;
      RDWAIT: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion events: write completes at grant, read completes at rvalid
  always_comb begin
    c_inc = (issue && !win_d && win_we) || (capture && !sel_q);
    d_inc = (issue &&  win_d && win_we) || (capture &&  sel_q);
  end

  // Request latch, memory strobes, grant/rvalid pulses, read data and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      wr       <= 1'b0;
      rd       <= 1'b0;
      addr     <= '0;
      wr_data  <= '0;
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
      c_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      wr       <= 1'b0;
      rd       <= 1'b0;
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (issue) begin
        sel_q   <= win_d;
        we_q    <= win_we;
        last_q  <= win_d;
        addr    <= win_addr;
        wr_data <= win_wdata;
        wr      <= win_we;
        rd      <= ~win_we;
        c_gnt   <= ~win_d;
        d_gnt   <= win_d;
      end
      if (capture) begin
        if (sel_q) begin
          d_rdata  <= rd_data;
          d_rvalid <= 1'b1;
        end else begin
          c_rdata  <= rd_data;
          c_rvalid <= 1'b1;
        end
      end
      if (c_inc && (c_cnt_q != CNT_MAX)) begin
        c_cnt_q <= c_cnt_q + CNT_W'(1);
      end
      if (d_inc && (d_cnt_q != CNT_MAX)) begin
        d_cnt_q <= d_cnt_q + CNT_W'(1);
      end
    end
  end

  assign c_cnt      = c_cnt_q;
  assign d_cnt      = d_cnt_q;
  assign core_stall = c_req && !(c_gnt && c_we) && !c_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level scheduling model plus directed literal checks.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          core_stall, wr, rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [15:0]   c_cnt, d_cnt;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .core_stall(core_stall), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .c_cnt(c_cnt), .d_cnt(d_cnt)
  );

  // Memory attached to the arbiter: read data valid the cycle after rd
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + DW'(i);
  always @(posedge clk) begin
    if (wr) mem[addr] <= wr_data;
    rd_data <= rd ? mem[addr] : '0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: when each access is issued and when it completes
  int            cyc = 0;
  int            next_sample = 0;
  bit            m_last_d = 1'b1;
  bit            e_wr, e_rd, e_cg, e_dg, e_crv, e_drv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            rv_pending = 1'b0;
  int            rv_cycle;
  bit            rv_d;
  logic [DW-1:0] rv_data;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_ccnt = 0, m_dcnt = 0;
  logic [DW-1:0] m_crdata = '0, m_drdata = '0;
  initial for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h1000_0000 + DW'(i);

  function automatic void bump(input bit is_d);
    if (is_d) begin
      if (m_dcnt < 65535) m_dcnt++;
    end else begin
      if (m_ccnt < 65535) m_ccnt++;
    end
  endfunction

  always @(posedge clk) begin
    bit            wd, we;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    e_wr = 0; e_rd = 0; e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0;
    if (reset) begin
      next_sample = cyc + 1;
      rv_pending  = 1'b0;
      m_ccnt = 0; m_dcnt = 0;
      m_crdata = '0; m_drdata = '0;
      m_last_d = 1'b1;
    end else begin
      if (rv_pending && rv_cycle == cyc + 1) begin
        rv_pending = 1'b0;
        if (rv_d) begin e_drv = 1; m_drdata = rv_data; end
        else      begin e_crv = 1; m_crdata = rv_data; end
        bump(rv_d);
      end
      if (cyc >= next_sample && (c_req || d_req)) begin
        wd = (c_req && d_req) ? !m_last_d : d_req;
        m_last_d = wd;
        we = wd ? d_we : c_we;
        a  = wd ? d_addr : c_addr;
        w  = wd ? d_wdata : c_wdata;
        e_addr = a;
        e_cg = !wd;
        e_dg = wd;
        if (we) begin
          e_wr = 1; e_wdata = w; ref_mem[a] = w; bump(wd);
          next_sample = cyc + 2;
        end else begin
          e_rd = 1; rv_pending = 1'b1; rv_cycle = cyc + 3; rv_d = wd; rv_data = ref_mem[a];
          next_sample = cyc + 3;
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr", wr, e_wr);
      chk("rd", rd, e_rd);
      chk("wr_rd_excl", wr & rd, 0);
      chk("c_gnt", c_gnt, e_cg);
      chk("d_gnt", d_gnt, e_dg);
      chk("c_rvalid", c_rvalid, e_crv);
      chk("d_rvalid", d_rvalid, e_drv);
      chk("c_rdata", c_rdata, m_crdata);
      chk("d_rdata", d_rdata, m_drdata);
      chk("c_cnt", c_cnt, 64'(m_ccnt));
      chk("d_cnt", d_cnt, 64'(m_dcnt));
      chk("core_stall", core_stall, c_req && !(e_cg && c_we) && !e_crv);
      if (e_wr || e_rd) chk("addr", addr, e_addr);
      if (e_wr) chk("wr_data", wr_data, e_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random requester: raises requests, drops req on the cycle after its grant
  task automatic drive_port(input bit is_d, input int n);
    bit g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g = is_d ? d_gnt : c_gnt;
      tick();
      if (is_d) begin
        if (g) d_req = 1'b0;
        else if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = AW'($urandom_range(0, 7)); d_wdata = $urandom;
        end
      end else begin
        if (g) c_req = 1'b0;
        else if (!c_req && $urandom_range(0, 2) == 0) begin
          c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
          c_addr = AW'($urandom_range(0, 7)); c_wdata = $urandom;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_c_cnt", c_cnt, 0);
    chk("rst_c_rdata", c_rdata, 0);
    tick();

    // Core write
    tick();
    c_req = 1; c_we = 1; c_addr = 9'h010; c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_stall_c0", core_stall, 1);
    @(negedge clk);
    chk("t1_wr", wr, 1);
    chk("t1_addr", addr, 9'h010);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_c_gnt", c_gnt, 1);
    chk("t1_c_cnt", c_cnt, 1);
    tick();
    c_req = 0;
    repeat (2) tick();

    // Core read of the same word
    c_req = 1; c_we = 0; c_addr = 9'h010;
    @(negedge clk);
    chk("t2_stall_c0", core_stall, 1);
    @(negedge clk);
    chk("t2_rd", rd, 1);
    chk("t2_c_gnt", c_gnt, 1);
    chk("t2_stall_c1", core_stall, 1);
    @(negedge clk);
    chk("t2_stall_c2", core_stall, 1);
    tick();
    c_req = 0;
    @(negedge clk);
    chk("t2_c_rvalid", c_rvalid, 1);
    chk("t2_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("t2_c_cnt", c_cnt, 2);
    repeat (3) tick();

    // Both ports writing continuously from reset release
    reset = 1;
    tick();
    reset = 0;
    c_req = 1; c_we = 1; c_addr = 9'h020; c_wdata = 32'h0000_C0DE;
    d_req = 1; d_we = 1; d_addr = 9'h021; d_wdata = 32'h0000_D0DE;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("t3_wr", wr, (k % 2) == 1);
        chk("t3_c_gnt", c_gnt, (k == 1) || (k == 5));
        chk("t3_d_gnt", d_gnt, (k == 3) || (k == 7));
      end
    end
    tick();
    c_req = 0; d_req = 0;
    repeat (4) tick();

    // Reset during RDWAIT of a debug read
    d_req = 1; d_we = 0; d_addr = 9'h021;
    tick();
    d_req = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("t4_wr", wr, 0);
    chk("t4_rd", rd, 0);
    chk("t4_c_gnt", c_gnt, 0);
    chk("t4_d_gnt", d_gnt, 0);
    chk("t4_c_rvalid", c_rvalid, 0);
    chk("t4_d_rvalid", d_rvalid, 0);
    chk("t4_addr", addr, 0);
    chk("t4_wr_data", wr_data, 0);
    chk("t4_c_rdata", c_rdata, 0);
    chk("t4_d_rdata", d_rdata, 0);
    chk("t4_c_cnt", c_cnt, 0);
    chk("t4_d_cnt", d_cnt, 0);
    @(negedge clk);
    chk("t4_d_rvalid_late", d_rvalid, 0);
    tick();

    // Debug counter saturation from a preloaded value
    force dut.d_cnt_q = 16'hFFFE;
    m_dcnt = 16'hFFFE;
    tick();
    release dut.d_cnt_q;
    d_req = 1; d_we = 1; d_addr = 9'h030; d_wdata = 32'h5A5A_5A5A;
    repeat (5) tick();
    d_req = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_d_cnt_sat", d_cnt, 16'hFFFF);

    // Random mixed traffic
    tick();
    fork
      drive_port(1'b0, 600);
      drive_port(1'b1, 600);
    join
    c_req = 0; d_req = 0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of all data buses.
REQ-002 Parameter ADDR_W, default 9, word-address width of data memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 c_req  input  1  core MEM-stage access request.
REQ-006 c_we  input  1  core request is write (1) or read (0).
REQ-007 c_addr  input  ADDR_W  core request address.
REQ-008 c_wdata  input  DATA_W  core write data.
REQ-009 c_gnt  output  1  one-cycle pulse: core request issued to memory.
REQ-010 c_rvalid  output  1  one-cycle pulse: c_rdata valid.
REQ-011 c_rdata  output  DATA_W  core read data.
REQ-012 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: debug/loader port, same directions, widths and meanings as the c_ signals.
REQ-013 core_stall  output  1  combinational: c_req high and request not yet completed.
REQ-014 wr  output  1  memory write strobe.
REQ-015 rd  output  1  memory read strobe.
REQ-016 addr  output  ADDR_W  memory address.
REQ-017 wr_data  output  DATA_W  memory write data.
REQ-018 rd_data  input  DATA_W  memory read data, valid the cycle after rd.
REQ-019 c_cnt, d_cnt  output  16  completed-access counters per port.

Function
REQ-020 FSM states IDLE, ISSUE, RDWAIT; exactly one access in flight.
REQ-021 IDLE: if any req sampled high, latch winner id, we, addr, wdata; go ISSUE; else stay IDLE.
REQ-022 Arbitration round-robin: single requester wins; both requesting -> winner is port not equal to last_gnt.
REQ-023 last_gnt updated to winner on IDLE->ISSUE transition.
REQ-024 ISSUE (one cycle): wr=we_latched, rd=!we_latched, addr/wr_data from latch; winner gnt pulses high.
REQ-025 ISSUE exit: write -> IDLE; read -> RDWAIT.
REQ-026 RDWAIT (one cycle): winner rdata captures rd_data, winner rvalid pulses high the following cycle; go IDLE.
REQ-027 Latency: write request sampled cycle N -> wr and gnt at N+1; read sampled N -> rd and gnt at N+1, rvalid with data at N+3.
REQ-028 c_rdata/d_rdata hold last captured value until next read completion on that port.
REQ-029 Requester holds req, we, addr, wdata stable until its gnt; req deasserted before gnt is legal only in IDLE cycles and cancels nothing already latched.
REQ-030 Requester drops req on cycle after gnt; a req still high in the IDLE cycle after completion is treated as a new request.
REQ-031 core_stall = c_req AND NOT (c_gnt AND c_we) AND NOT c_rvalid.
REQ-032 wr and rd never both high; neither high outside ISSUE.
REQ-033 c_cnt/d_cnt increment by 1 on write gnt or read rvalid of their port; saturate at 16'hFFFF.
REQ-034 Throughput: write every 2 cycles, read every 3 cycles, under continuous request.
REQ-035 Both requesting continuously: grants strictly alternate c, d, c, d.

Reset
REQ-036 Reset sampled high: next state IDLE, in-flight access dropped, no gnt/rvalid for it.
REQ-037 After reset: wr, rd, c_gnt, d_gnt, c_rvalid, d_rvalid = 0; addr, wr_data, c_rdata, d_rdata = 0; c_cnt, d_cnt = 0; last_gnt = d (core wins first tie).
REQ-038 Reset overrides all inputs, including a read in RDWAIT.

Verification
REQ-039 Core write c_addr=9'h010, c_wdata=32'hDEADBEEF at cycle 0 -> wr=1, addr=9'h010, wr_data=32'hDEADBEEF, c_gnt=1 at cycle 1; c_cnt=1.
REQ-040 Core read 9'h010 at cycle 0, memory returns 32'hDEADBEEF -> rd=1 at cycle 1, c_rvalid=1, c_rdata=32'hDEADBEEF at cycle 3; core_stall high cycles 0-2.
REQ-041 c_req and d_req both high from reset release, writes -> gnt order c, d, c, d; wr pulses at cycles 1, 3, 5, 7.
REQ-042 Reset asserted during RDWAIT of debug read -> no d_rvalid, d_cnt unchanged, all outputs 0 next cycle, FSM IDLE.
REQ-043 d_cnt preloaded to 16'hFFFE via 2^16-2 debug writes, 3 more writes -> d_cnt=16'hFFFF, stays.
REQ-044 Random c/d traffic with memory model -> every read returns last written value; wr and rd never both high.
